v_hier_sub_sched: RTL and testbench
===================================

// Module: v_hier_sub_sched
// PURPOSE
//  Scheduler that shares one v_hier_sub datapath between NREQ requesters.
//  Grants one requester at a time (round-robin) and drives its operand onto sub_avec.
//  Holds the operand for LAT cycles, then samples sub_qvec.
//  Returns the result with the requester id over a valid/ready response port.
//  Sits between the requester blocks and the single v_hier_sub instance in the hierarchy.
// PARAMETERS
//  NREQ   4  number of requesters (2..16)
//  WIDTH  4  operand/result width; matches v_hier_sub avec/qvec
//  LAT    2  cycles sub_avec is held stable before sub_qvec is sampled (>=1)
//  IDW    $clog2(NREQ)  localparam, width of requester id
// PORTS
//  clk        in   1           sole clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  req_valid  in   NREQ        per-requester request pending
//  req_data   in   NREQ*WIDTH  operand; requester i at [i*WIDTH +: WIDTH]
//  req_ready  out  NREQ        one-hot accept strobe (combinational from state/pointer)
//  rsp_valid  out  1           result available (registered)
//  rsp_ready  in   1           consumer accepts result
//  rsp_id     out  IDW         requester index of the result
//  rsp_data   out  WIDTH       sampled sub_qvec
//  sub_avec   out  WIDTH       to v_hier_sub avec (registered)
//  sub_qvec   in   WIDTH       from v_hier_sub qvec
//  busy       out  1           state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; rr pointer=0 (requester 0 has highest priority).
//   - sub_avec=0, rsp_valid=0, rsp_id=0, rsp_data=0, cnt=0, busy=0.
//   - req_ready=0 while rst_n=0.
//  FSM states: IDLE, WAIT, RESP.
//  IDLE:
//   - g = first i with req_valid[i], searching from ptr upward, wrapping at NREQ-1.
//   - If any request is pending: req_ready[g]=1 in the same cycle.
//   - On the edge: latch req_data[g] into sub_avec, rsp_id<=g, ptr<=(g+1)%NREQ, cnt<=LAT, go to WAIT.
//   - If no request is pending: req_ready=0, ptr unchanged.
//  WAIT:
//   - sub_avec held constant; cnt decrements each cycle.
//   - On the edge where cnt==1: rsp_data<=sub_qvec, go to RESP.
//   - sub_avec is therefore stable for exactly LAT cycles before the sample.
//  RESP:
//   - rsp_valid=1. rsp_id and rsp_data are held until rsp_valid&&rsp_ready.
//   - On the handshake edge: rsp_valid<=0, sub_avec<=0, go to IDLE.
//  Latency: grant cycle T0 -> rsp_valid asserted at T0+LAT+1.
//  Minimum spacing between grants: LAT+2 cycles (one IDLE bubble after every response).
//  Boundaries:
//   - req_ready is never asserted outside IDLE; requests held during WAIT/RESP wait.
//   - A requester that drops req_valid before its grant is skipped; no state change.
//   - Simultaneous handshake and new requests: go to IDLE first; grant on the next cycle.
//   - ptr wraps NREQ-1 -> 0. A single requester is granted back-to-back (no lockout).
//   - Backpressure: rsp_ready=0 holds RESP indefinitely with outputs stable.
//   - Reset mid-transaction aborts it: no response, outputs return to reset values.
// STRUCTURE
//  Package v_hier_pkg holds:
//   - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
//   - default WIDTH and LAT constants
//  Sub-module v_hier_rr_pick: combinational round-robin selector.
//   - Inputs: req, ptr. Outputs: grant one-hot, gidx, any.
//  Top level holds the FSM, LAT counter and output registers.
// TESTING
//  Assertions checked on every cycle:
//   - req_ready is one-hot or zero.
//   - sub_avec is stable throughout WAIT.
//   - rsp fields are stable while rsp_valid && !rsp_ready.
//  Directed scenarios:
//   1. Single request: req_valid=4'b0100, data[2]=4'hA, LAT=2
//      -> req_ready=4'b0100 at T0; sub_avec=A at T1..T2; rsp_valid at T3, rsp_id=2.
//   2. All four requesting continuously, rsp_ready=1
//      -> grant order 0,1,2,3,0; grants spaced exactly 4 cycles apart.
//   3. Backpressure: rsp_ready=0 for 5 cycles in RESP
//      -> rsp_valid, rsp_id, rsp_data stable; req_ready=0; next grant 1 cycle after handshake.
//   4. Model returns qvec=avec^4'hF: request data 4'h3
//      -> rsp_data=4'hC; sampled value matches the model on the cnt==1 edge.
//   5. rst_n pulsed low during WAIT
//      -> all outputs 0 immediately; no response; first grant after release goes to requester 0.
//   6. Requester 1 drops req_valid in the cycle before its turn
//      -> skipped; requester 2 granted; ptr=3.

Source files
------------

// File: rtl/v_hier_pkg.sv
// Shared types and default sizing for the v_hier scheduler slice.
package v_hier_pkg;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_LAT   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/v_hier_rr_pick.sv
// Combinational round-robin selector: first pending request at or above ptr, wrapping.
module v_hier_rr_pick
    import v_hier_pkg::*;
#(
    parameter  int unsigned NREQ = DEF_NREQ,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gidx,
    output logic            any
);

    // Index arithmetic is one bit wider so non-power-of-two NREQ wraps correctly.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                gidx       = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/v_hier_sub_sched.sv
// Shares one v_hier_sub datapath among NREQ requesters: round-robin grant,
// hold operand LAT cycles, sample result, return it over a valid/ready port.
module v_hier_sub_sched
    import v_hier_pkg::*;
#(
    parameter  int unsigned NREQ  = DEF_NREQ,
    parameter  int unsigned WIDTH = DEF_WIDTH,
    parameter  int unsigned LAT   = DEF_LAT,
    localparam int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [WIDTH-1:0]      sub_avec,
    input  logic [WIDTH-1:0]      sub_qvec,
    output logic                  busy
);

    localparam int unsigned CNTW = $clog2(LAT + 1);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sub_avec_q, sub_avec_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic             any;
    logic [WIDTH-1:0] sel_data;

    v_hier_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    // Operand mux for the winning requester.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        sub_avec_d  = sub_avec_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        req_ready   = '0;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    // Gated by rst_n so no accept strobe is seen while reset is held.
                    req_ready  = rst_n ? grant : '0;
                    sub_avec_d = sel_data;
                    rsp_id_d   = gidx;
                    ptr_d      = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
                    cnt_d      = CNTW'(LAT);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    rsp_data_d  = sub_qvec;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    sub_avec_d  = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            sub_avec_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sub_avec_q  <= sub_avec_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign sub_avec  = sub_avec_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_v_hier_sub_sched.sv
// Directed bench for v_hier_sub_sched: expected responses queued at grant time,
// a negedge monitor pops and compares on each response handshake.
module tb_v_hier_sub_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned IDW   = 2;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic [WIDTH-1:0]      sub_avec;
    logic [WIDTH-1:0]      sub_qvec;
    logic                  busy;

    int   total;
    int   bad;
    exp_t expq[$];

    v_hier_sub_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .sub_avec  (sub_avec),
        .sub_qvec  (sub_qvec),
        .busy      (busy)
    );

    // Datapath model: result is the bitwise inverse of the operand.
    assign sub_qvec = sub_avec ^ 4'hF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [WIDTH-1:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        expq.push_back(e);
    endtask

    // Monitor: scoreboard pops plus per-cycle invariants.
    logic             prev_wait;
    logic             prev_hold;
    logic [WIDTH-1:0] prev_avec;
    logic [IDW-1:0]   prev_id;
    logic [WIDTH-1:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait = 1'b0;
            prev_hold = 1'b0;
        end else begin
            chk("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (prev_wait && busy && !rsp_valid) begin
                chk("avec_stable_wait", 32'(sub_avec), 32'(prev_avec));
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_id", 32'(rsp_id), 32'(prev_id));
                chk("hold_data", 32'(rsp_data), 32'(prev_data));
            end
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp actual id=%0h data=%0h required none", rsp_id, rsp_data);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                end
            end
            prev_wait = busy && !rsp_valid;
            prev_hold = rsp_valid && !rsp_ready;
            prev_avec = sub_avec;
            prev_id   = rsp_id;
            prev_data = rsp_data;
        end
    end

    initial begin
        logic [WIDTH-1:0] s2_exp [NREQ];
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = 16'hD741;
        rsp_ready = 1'b1;
        s2_exp    = '{4'hE, 4'hB, 4'h8, 4'h2};

        // Reset state, including no accept strobe while requests are pending.
        #2;
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_sub_avec", 32'(sub_avec), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;

        // Single request from requester 2, operand A.
        req_data  = 16'hDA41;
        req_valid = 4'b0100;
        #1 chk("s1_grant", 32'(req_ready), 32'b0100);
        push(2'd2, 4'h5);
        step();
        req_valid = '0;
        #1;
        chk("s1_avec_t1", 32'(sub_avec), 32'hA);
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_ready_wait", 32'(req_ready), 32'd0);
        step();
        #1;
        chk("s1_avec_t2", 32'(sub_avec), 32'hA);
        chk("s1_valid_t2", 32'(rsp_valid), 32'd0);
        step();
        #1;
        chk("s1_valid_t3", 32'(rsp_valid), 32'd1);
        chk("s1_id_t3", 32'(rsp_id), 32'd2);
        step();
        #1;
        chk("s1_valid_t4", 32'(rsp_valid), 32'd0);
        chk("s1_busy_t4", 32'(busy), 32'd0);

        // Operand 3 through the inverting model -> C; ptr=3 wraps to requester 0.
        req_data  = 16'hDA43;
        req_valid = 4'b0001;
        #1 chk("s4_grant", 32'(req_ready), 32'b0001);
        push(2'd0, 4'hC);
        step();
        req_valid = '0;
        step();
        step();
        #1 chk("s4_rsp_data", 32'(rsp_data), 32'hC);
        step();

        // Reset pulse during WAIT aborts the transaction.
        req_data  = 16'hD741;
        req_valid = 4'b1000;
        #1 chk("s5_grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b1111;
        #1;
        chk("s5_busy_wait", 32'(busy), 32'd1);
        chk("s5_avec_wait", 32'(sub_avec), 32'hD);
        #1 rst_n = 1'b0;
        #1;
        chk("s5_rst_avec", 32'(sub_avec), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        chk("s5_rst_ready", 32'(req_ready), 32'd0);
        chk("s5_rst_valid", 32'(rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;

        // All four requesting: grants 0,1,2,3,0 spaced four cycles apart.
        for (int k = 0; k < 5; k++) begin
            logic [NREQ-1:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            #1 chk("s2_grant", 32'(req_ready), 32'(exp_g));
            push(IDW'(k % 4), s2_exp[k % 4]);
            step();
            if (k == 4) req_valid = '0;
            for (int c = 0; c < 3; c++) begin
                #1 chk("s2_gap_ready", 32'(req_ready), 32'd0);
                step();
            end
        end

        // Backpressure: five cycles of rsp_ready=0 in RESP.
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1 chk("s3_grant", 32'(req_ready), 32'b0010);
        push(2'd1, 4'hB);
        step();
        req_valid = 4'b0001;
        #1 chk("s3_ready_t1", 32'(req_ready), 32'd0);
        step();
        #1 chk("s3_ready_t2", 32'(req_ready), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s3_bp_valid", 32'(rsp_valid), 32'd1);
            chk("s3_bp_id", 32'(rsp_id), 32'd1);
            chk("s3_bp_data", 32'(rsp_data), 32'hB);
            chk("s3_bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1 chk("s3_hs_valid", 32'(rsp_valid), 32'd1);
        step();
        #1 chk("s3_next_grant", 32'(req_ready), 32'b0001);
        push(2'd0, 4'hE);
        step();
        req_valid = '0;
        step();
        step();
        step();

        // Requester 1 withdraws just before its turn: requester 2 wins, ptr -> 3.
        req_valid = 4'b1101;
        #1 chk("s6_skip_grant", 32'(req_ready), 32'b0100);
        push(2'd2, 4'h8);
        step();
        req_valid = 4'b1111;
        step();
        step();
        step();
        req_valid = 4'b1000;
        #1 chk("s6_ptr3_grant", 32'(req_ready), 32'b1000);
        push(2'd3, 4'h2);
        repeat (4) step();
        #1 chk("b2b_grant", 32'(req_ready), 32'b1000);
        push(2'd3, 4'h2);
        step();
        req_valid = '0;

        // Drain the scoreboard within a bounded window.
        for (int w = 0; w < 20 && expq.size() != 0; w++) step();
        chk("queue_drained", 32'(expq.size()), 32'd0);
        #1 chk("end_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
